// File: rtl/pulse_spacer.sv
// pulse_spacer: source-side pacing stage for the clkA side of the handshake
// pulse synchronizer. Buffers incoming single-cycle events in a saturating
// pending counter. Replays them as single-cycle pulses, each followed by at
// least GAP idle cycles so the Req/Ack round trip finishes before the next launch.
module pulse_spacer #(
    parameter int GAP   = 8,
    parameter int CNT_W = 4
) (
    input  logic             clkA,
    input  logic             rst_n,
    input  logic             evt_in,
    input  logic             clr_ovf,
    output logic             pulse_out,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             busy
);

    localparam logic [0:0]       S_IDLE  = 1'b0;
    localparam logic [0:0]       S_GAP   = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [7:0]       GAP_LD  = 8'(GAP);

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic [7:0] gap_cnt;
    logic [7:0] gap_cnt_nxt;
    logic       pulse_nxt;
    logic       emit;
    logic       inc;
    logic       drop;

    // Emit decision uses the pre-edge pending value, so an event is never
    // replayed on the same edge at which it is sampled.
    assign emit = (state == S_IDLE) && (pending != '0);
    // At full, an event is only accepted when an emit frees a slot on the same edge.
    assign inc  = evt_in && ((pending != CNT_MAX) || emit);
    assign drop = evt_in && !inc;
    assign busy = (pending != '0) || (state == S_GAP);

    // FSM next-state, gap counter and pulse decisions.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        pulse_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (emit) begin
                    pulse_nxt   = 1'b1;
                    gap_cnt_nxt = GAP_LD;
                    state_nxt   = S_GAP;
                end
            end
            default: begin
                if (gap_cnt == 8'd1) begin
                    state_nxt = S_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 8'd1;
                end
            end
        endcase
    end

    // State, gap counter and registered pulse output.
    always_ff @(posedge clkA or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state     <= S_IDLE;
            gap_cnt   <= '0;
            pulse_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            gap_cnt   <= gap_cnt_nxt;
            pulse_out <= pulse_nxt;
        end
    end

    // Saturating pending counter: +1 on accepted event, -1 on emit.
    always_ff @(posedge clkA or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (inc && !emit) begin
            pending <= pending + 1'b1;
        end else if (emit && !inc) begin
            pending <= pending - 1'b1;
        end
    end

    // Sticky overflow flag; a drop wins over a simultaneous clear.
    always_ff @(posedge clkA or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_spacer.sv
// Directed bench for pulse_spacer: three instances cover GAP=8/CNT_W=4,
// GAP=4/CNT_W=4 and GAP=8/CNT_W=2. Inputs change and outputs are sampled
// on the falling edge, so each sample shows the state just after a rising edge.
module tb_pulse_spacer;

    logic clkA = 1'b0;
    logic rst_n = 1'b0;

    logic       evt_a = 1'b0, clr_a = 1'b0, pulse_a, ovf_a, busy_a;
    logic [3:0] pend_a;
    logic       evt_b = 1'b0, clr_b = 1'b0, pulse_b, ovf_b, busy_b;
    logic [3:0] pend_b;
    logic       evt_c = 1'b0, clr_c = 1'b0, pulse_c, ovf_c, busy_c;
    logic [1:0] pend_c;

    int errors = 0;
    int checks = 0;

    always #5 clkA = ~clkA;

    pulse_spacer #(.GAP(8), .CNT_W(4)) dut_a (
        .clkA(clkA), .rst_n(rst_n), .evt_in(evt_a), .clr_ovf(clr_a),
        .pulse_out(pulse_a), .pending(pend_a), .overflow(ovf_a), .busy(busy_a)
    );
    pulse_spacer #(.GAP(4), .CNT_W(4)) dut_b (
        .clkA(clkA), .rst_n(rst_n), .evt_in(evt_b), .clr_ovf(clr_b),
        .pulse_out(pulse_b), .pending(pend_b), .overflow(ovf_b), .busy(busy_b)
    );
    pulse_spacer #(.GAP(8), .CNT_W(2)) dut_c (
        .clkA(clkA), .rst_n(rst_n), .evt_in(evt_c), .clr_ovf(clr_c),
        .pulse_out(pulse_c), .pending(pend_c), .overflow(ovf_c), .busy(busy_c)
    );

    task automatic step();
        @(posedge clkA);
        @(negedge clkA);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({pulse_a, pend_a, ovf_a, busy_a} !== 7'b0) begin
            errors++;
            $display("FAIL reset_a: got pulse=%b pend=%0d ovf=%b busy=%b, want all 0",
                     pulse_a, pend_a, ovf_a, busy_a);
        end
        checks++;
        if ({pulse_c, pend_c, ovf_c, busy_c} !== 5'b0) begin
            errors++;
            $display("FAIL reset_c: got pulse=%b pend=%0d ovf=%b busy=%b, want all 0",
                     pulse_c, pend_c, ovf_c, busy_c);
        end
        @(negedge clkA);
        rst_n = 1'b1;
        step();
    endtask

    // GAP=8: event at E0, pulse only after E1, busy through the gap.
    task automatic test_single();
        int npulse = 0;
        for (int i = 0; i <= 10; i++) begin
            evt_a = (i == 0);
            step();
            if (pulse_a) npulse++;
            if (i == 0) begin
                checks++;
                if (pend_a !== 4'd1 || pulse_a !== 1'b0) begin
                    errors++;
                    $display("FAIL single_e0: got pend=%0d pulse=%b, want 1/0", pend_a, pulse_a);
                end
            end
            if (i == 1) begin
                checks++;
                if (pend_a !== 4'd0 || pulse_a !== 1'b1) begin
                    errors++;
                    $display("FAIL single_e1: got pend=%0d pulse=%b, want 0/1", pend_a, pulse_a);
                end
            end
            if (i == 2) begin
                checks++;
                if (pulse_a !== 1'b0) begin
                    errors++;
                    $display("FAIL single_e2_pulse: got %b, want 0", pulse_a);
                end
            end
            if (i == 8) begin
                checks++;
                if (busy_a !== 1'b1) begin
                    errors++;
                    $display("FAIL single_busy_e8: got %b, want 1", busy_a);
                end
            end
            if (i == 10) begin
                checks++;
                if (busy_a !== 1'b0) begin
                    errors++;
                    $display("FAIL single_busy_e10: got %b, want 0", busy_a);
                end
            end
        end
        evt_a = 1'b0;
        checks++;
        if (npulse != 1) begin
            errors++;
            $display("FAIL single_count: got %0d pulses, want 1", npulse);
        end
    endtask

    // GAP=4: three back-to-back events, pulses after E1, E6, E11.
    task automatic test_back_to_back();
        int exp_pend [15] = '{1, 1, 2, 2, 2, 2, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        logic [14:0] exp_pulse = 15'b000_1000_0100_0010;
        for (int i = 0; i < 15; i++) begin
            evt_b = (i < 3);
            step();
            checks++;
            if (pend_b !== 4'(exp_pend[i]) || pulse_b !== exp_pulse[i]) begin
                errors++;
                $display("FAIL burst_e%0d: got pend=%0d pulse=%b, want pend=%0d pulse=%b",
                         i, pend_b, pulse_b, exp_pend[i], exp_pulse[i]);
            end
        end
        evt_b = 1'b0;
        checks++;
        if (ovf_b !== 1'b0) begin
            errors++;
            $display("FAIL burst_ovf: got %b, want 0", ovf_b);
        end
    endtask

    // CNT_W=2, GAP=8: fill to 3 while in GAP, then drive an event on the
    // emit edge (E10); then a drop colliding with clr_ovf.
    task automatic test_full_emit_and_clear();
        for (int i = 0; i <= 9; i++) begin
            evt_c = (i < 4);
            step();
        end
        checks++;
        if (pend_c !== 2'd3 || pulse_c !== 1'b0 || busy_c !== 1'b1) begin
            errors++;
            $display("FAIL full_pre: got pend=%0d pulse=%b busy=%b, want 3/0/1",
                     pend_c, pulse_c, busy_c);
        end
        evt_c = 1'b1;
        step();
        checks++;
        if (pend_c !== 2'd3 || ovf_c !== 1'b0 || pulse_c !== 1'b1) begin
            errors++;
            $display("FAIL full_emit: got pend=%0d ovf=%b pulse=%b, want 3/0/1",
                     pend_c, ovf_c, pulse_c);
        end
        clr_c = 1'b1;
        step();
        checks++;
        if (ovf_c !== 1'b1 || pend_c !== 2'd3) begin
            errors++;
            $display("FAIL ovf_collide: got ovf=%b pend=%0d, want 1/3", ovf_c, pend_c);
        end
        evt_c = 1'b0;
        step();
        clr_c = 1'b0;
        checks++;
        if (ovf_c !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b, want 0", ovf_c);
        end
        begin
            int n = 0;
            while (busy_c && n < 100) begin
                step();
                n++;
            end
            checks++;
            if (busy_c !== 1'b0 || pend_c !== 2'd0) begin
                errors++;
                $display("FAIL drain_timeout: got busy=%b pend=%0d after %0d cycles, want 0/0",
                         busy_c, pend_c, n);
            end
        end
    endtask

    // CNT_W=2, GAP=8: five events, the fifth is dropped; four pulses total.
    task automatic test_overflow();
        int npulse = 0;
        int peak = 0;
        logic prev = 1'b0;
        int consec = 0;
        for (int i = 0; i < 50; i++) begin
            evt_c = (i < 5);
            step();
            if (pulse_c) npulse++;
            if (pulse_c && prev) consec++;
            prev = pulse_c;
            if (int'(pend_c) > peak) peak = int'(pend_c);
            if (i == 3) begin
                checks++;
                if (ovf_c !== 1'b0 || pend_c !== 2'd3) begin
                    errors++;
                    $display("FAIL ovf_e3: got ovf=%b pend=%0d, want 0/3", ovf_c, pend_c);
                end
            end
            if (i == 4) begin
                checks++;
                if (ovf_c !== 1'b1 || pend_c !== 2'd3) begin
                    errors++;
                    $display("FAIL ovf_e4: got ovf=%b pend=%0d, want 1/3", ovf_c, pend_c);
                end
            end
        end
        evt_c = 1'b0;
        checks++;
        if (npulse != 4 || peak != 3) begin
            errors++;
            $display("FAIL ovf_totals: got pulses=%0d peak=%0d, want 4/3", npulse, peak);
        end
        checks++;
        if (consec != 0) begin
            errors++;
            $display("FAIL ovf_consecutive: got %0d back-to-back pulses, want 0", consec);
        end
    endtask

    // GAP=8: reset with pending=2 in GAP; outputs clear at once, no pulse after.
    task automatic test_reset_mid_gap();
        int npulse = 0;
        for (int i = 0; i < 4; i++) begin
            evt_a = (i < 3);
            step();
        end
        evt_a = 1'b0;
        checks++;
        if (pend_a !== 4'd2 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: got pend=%0d busy=%b, want 2/1", pend_a, busy_a);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({pulse_a, pend_a, ovf_a, busy_a} !== 7'b0) begin
            errors++;
            $display("FAIL rst_async: got pulse=%b pend=%0d ovf=%b busy=%b, want all 0",
                     pulse_a, pend_a, ovf_a, busy_a);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (pulse_a) npulse++;
        end
        checks++;
        if (npulse != 0 || pend_a !== 4'd0) begin
            errors++;
            $display("FAIL rst_after: got pulses=%0d pend=%0d, want 0/0", npulse, pend_a);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_emit_and_clear();
        test_overflow();
        test_reset_mid_gap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
